// File: rtl/stream_element_packer.sv
// Accepts one delimited stream element per handshake, validates its framing and
// packs accepted elements back-to-back onto a fixed-width output bus.
module stream_element_packer #(
  parameter int          DATA_BUS_WIDTH_BYTES     = 8,
  parameter int          MAX_USE_BYTES            = 38,
  parameter int          FIXEDFIELD_LENGTH_BYTES  = 17,
  parameter int          MAX_VARIABLEFIELD_LENGTH = 16,
  parameter logic [7:0]  VARIABLEFIELD_DELIMITER  = 8'h2C
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [MAX_USE_BYTES*8-1:0]        use_in,
  input  logic [5:0]                        use_len_in,
  input  logic                              use_ready_in,
  output logic                              use_ack_out,
  input  logic                              flush_in,
  output logic [DATA_BUS_WIDTH_BYTES*8-1:0] data_out,
  output logic [DATA_BUS_WIDTH_BYTES-1:0]   data_keep_out,
  output logic                              data_valid_out,
  input  logic                              data_ready_in,
  output logic                              format_error_out,
  output logic [15:0]                       elements_sent_out,
  output logic [1:0]                        fsm_state_o
);

  localparam int DW        = DATA_BUS_WIDTH_BYTES;
  localparam int BUF_BYTES = MAX_USE_BYTES + DW - 1;
  localparam int CW        = $clog2(BUF_BYTES + 1);
  localparam logic [CW-1:0] DW_C = CW'(DW);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_EMIT, S_FLUSH} state_t;

  state_t                     state_q;
  logic                       run_q;
  logic [MAX_USE_BYTES*8-1:0] elem_q;
  logic [5:0]                 len_q;
  logic [BUF_BYTES*8-1:0]     buf_q;
  logic [CW-1:0]              count_q;
  logic                       valid_q;
  logic [DW-1:0]              keep_q;
  logic [15:0]                sent_q;

  logic                       ack_fire;
  logic                       elem_ok;
  logic [MAX_USE_BYTES*8-1:0] elem_masked;
  logic [BUF_BYTES*8-1:0]     buf_load_d;
  logic [CW-1:0]              count_load_d;
  logic [CW-1:0]              count_shift_d;
  logic [DW-1:0]              flush_keep_d;

  // run_q keeps the ack quiet until the first clock after reset is released.
  assign ack_fire = (state_q == S_IDLE) && use_ready_in && run_q;

  always_comb begin
    elem_ok = 1'b0;
    for (int k = 1; k <= MAX_VARIABLEFIELD_LENGTH; k++) begin
      if (len_q == 6'(k + FIXEDFIELD_LENGTH_BYTES + 1))
        elem_ok = (elem_q[k*8 +: 8] == VARIABLEFIELD_DELIMITER);
    end
  end

  // Bytes past the element length are zeroed so the buffer tail stays clean.
  always_comb begin
    elem_masked = '0;
    for (int k = 0; k < MAX_USE_BYTES; k++) begin
      if (6'(k) < len_q) elem_masked[k*8 +: 8] = elem_q[k*8 +: 8];
    end
  end

  assign buf_load_d    = buf_q | ({{((DW-1)*8){1'b0}}, elem_masked} << {count_q, 3'b000});
  assign count_load_d  = count_q + CW'(len_q);
  assign count_shift_d = count_q - DW_C;

  always_comb begin
    flush_keep_d = '0;
    for (int k = 0; k < DW; k++) flush_keep_d[k] = (CW'(k) < count_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      run_q   <= 1'b0;
      elem_q  <= '0;
      len_q   <= '0;
      buf_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      keep_q  <= '0;
      sent_q  <= '0;
    end else begin
      run_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (ack_fire) begin
            elem_q  <= use_in;
            len_q   <= use_len_in;
            state_q <= S_CHECK;
          end else if (flush_in && (count_q != '0)) begin
            valid_q <= 1'b1;
            keep_q  <= flush_keep_d;
            state_q <= S_FLUSH;
          end
        end
        S_CHECK: begin
          if (elem_ok) begin
            buf_q   <= buf_load_d;
            count_q <= count_load_d;
            sent_q  <= sent_q + 16'd1;
            if (count_load_d >= DW_C) begin
              valid_q <= 1'b1;
              keep_q  <= '1;
              state_q <= S_EMIT;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_EMIT: begin
          // Words below a full bus width stay behind as residue.
          if (data_ready_in) begin
            buf_q   <= buf_q >> (DW*8);
            count_q <= count_shift_d;
            if (count_shift_d < DW_C) begin
              valid_q <= 1'b0;
              keep_q  <= '0;
              state_q <= S_IDLE;
            end
          end
        end
        S_FLUSH: begin
          if (data_ready_in) begin
            buf_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            keep_q  <= '0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Handshake: an element is consumed on the edge where use_ack_out is high;
  // a word is consumed on the edge where data_valid_out and data_ready_in are high.
  assign use_ack_out       = ack_fire;
  assign format_error_out  = (state_q == S_CHECK) && !elem_ok;
  assign data_valid_out    = valid_q;
  assign data_keep_out     = keep_q;
  assign data_out          = valid_q ? buf_q[DW*8-1:0] : '0;
  assign elements_sent_out = sent_q;
  assign fsm_state_o       = state_q;

endmodule
